// File: rtl/qspi_oversampled.sv
// Single-clock QSPI/DSPI/SPI target bridge: pins are oversampled in the clk domain and
// bytes move through RX/TX FIFOs to and from the bus consumer.
module qspi_oversampled #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic           clk,
    input  logic           async_reset_n,
    input  logic           qspi_clk,
    input  logic           qspi_ncs,
    inout  wire logic [3:0] qspi_io,
    output logic [7:0]     rd_data,
    output logic           rd_valid,
    input  logic           rd_ready,
    input  logic [7:0]     wr_data,
    output logic           wr_valid,
    input  logic           wr_ready,
    output logic           closed,
    output logic           rx_overflow,
    output logic           tx_underrun
);
    localparam int unsigned BEATS = 8 / LANES;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [1:0] {StIdle, StReceive, StSend} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync;
    logic [LANES-1:0]       io_sync [SYNC_STAGES];
    logic                   sclk_q, ncs_q;
    logic                   sclk_s, ncs_s, rise, fall, ncs_fall;
    logic [LANES-1:0]       lanes;
    logic [7-LANES:0]       rx_sh;
    logic [7:0]             rx_byte, tx_sh, load_byte;
    logic [2:0]             rx_beat, tx_beat;
    logic [LANES-1:0]       out_q;
    logic                   rx_rise, byte_done, rx_push, rx_do_push, rx_pop, rx_full;
    logic                   tx_fall, tx_load, tx_push, tx_pop, tx_empty;
    logic [7:0]             rx_mem [DEPTH];
    logic [7:0]             tx_mem [DEPTH];
    logic [AW-1:0]          rx_wr, rx_rd, tx_wr, tx_rd;
    logic [CW-1:0]          rx_cnt, tx_cnt;
    logic [3:0]             io_oe, io_out;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            sclk_sync <= '0;
            ncs_sync  <= '1;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) io_sync[i] <= '0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], qspi_clk};
            ncs_sync   <= {ncs_sync[SYNC_STAGES-2:0], qspi_ncs};
            sclk_q     <= sclk_s;
            ncs_q      <= ncs_s;
            io_sync[0] <= qspi_io[LANES-1:0];
            for (int i = 1; i < SYNC_STAGES; i++) io_sync[i] <= io_sync[i-1];
        end
    end

    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign ncs_s    = ncs_sync[SYNC_STAGES-1];
    assign lanes    = io_sync[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_q;
    assign fall     = ~sclk_s & sclk_q;
    assign ncs_fall = ~ncs_s & ncs_q;
    assign closed   = ncs_s;

    assign rx_full    = (rx_cnt == CW'(DEPTH));
    assign tx_empty   = (tx_cnt == '0);
    assign rd_valid   = (rx_cnt != '0);
    assign wr_valid   = (tx_cnt != CW'(DEPTH));
    assign rd_data    = rx_mem[rx_rd];
    assign byte_done  = (rx_beat == 3'(BEATS - 1));
    assign rx_byte    = {rx_sh, lanes};
    assign rx_rise    = (state_q == StReceive) && !ncs_s && rise;
    assign rx_push    = rx_rise && byte_done;
    assign rx_do_push = rx_push && !rx_full;
    // A consumer write also retires the RX head: those bytes are dummies clocked in during writes.
    assign rx_pop     = rd_valid && (rd_ready || wr_ready);
    assign tx_fall    = (state_q == StSend) && !ncs_s && fall;
    assign tx_load    = tx_fall && (tx_beat == '0);
    assign tx_pop     = tx_load && !tx_empty;
    assign tx_push    = wr_ready && wr_valid;
    assign load_byte  = tx_empty ? FILL_BYTE : tx_mem[tx_rd];

    always_comb begin
        state_d = state_q;
        if (ncs_s) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:    if (ncs_fall) state_d = StReceive;
                StReceive: if (rx_push && !tx_empty) state_d = StSend;
                default:   state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) state_q <= StIdle;
        else                state_q <= state_d;
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            rx_sh       <= '0;
            rx_beat     <= '0;
            tx_sh       <= '0;
            tx_beat     <= '0;
            out_q       <= '0;
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                rx_beat <= '0;
                tx_beat <= '0;
                out_q   <= '0;
                if (ncs_fall) begin
                    rx_overflow <= 1'b0;
                    tx_underrun <= 1'b0;
                end
            end
            if (rx_rise) begin
                rx_sh   <= rx_byte[7-LANES:0];
                rx_beat <= byte_done ? 3'd0 : rx_beat + 3'd1;
            end
            if (rx_push && rx_full) rx_overflow <= 1'b1;
            if (tx_fall) begin
                if (tx_beat == '0) begin
                    out_q <= load_byte[7 -: LANES];
                    tx_sh <= {load_byte[7-LANES:0], {LANES{1'b0}}};
                    if (tx_empty) tx_underrun <= 1'b1;
                end else begin
                    out_q <= tx_sh[7 -: LANES];
                    tx_sh <= {tx_sh[7-LANES:0], {LANES{1'b0}}};
                end
                tx_beat <= (tx_beat == 3'(BEATS - 1)) ? 3'd0 : tx_beat + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (rx_do_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)     rx_rd <= rx_rd + AW'(1);
            rx_cnt <= rx_cnt + CW'(rx_do_push) - CW'(rx_pop);
            if (tx_push)    tx_wr <= tx_wr + AW'(1);
            if (tx_pop)     tx_rd <= tx_rd + AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_do_push) rx_mem[rx_wr] <= rx_byte;
        if (tx_push)    tx_mem[tx_wr] <= wr_data;
    end

    // Single-lane mode returns data on io[1] (MISO); wider modes drive the low LANES lines.
    always_comb begin
        io_oe  = '0;
        io_out = '0;
        if (LANES == 1) begin
            io_oe[1]  = (state_q == StSend);
            io_out[1] = out_q[0];
        end else begin
            io_oe[LANES-1:0]  = {LANES{state_q == StSend}};
            io_out[LANES-1:0] = out_q;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_io
        assign qspi_io[g] = io_oe[g] ? io_out[g] : 1'bz;
    end
endmodule

// File: tb/tb_qspi_oversampled.sv
// Bench for qspi_oversampled: a 4-lane and a 1-lane instance driven by a host model,
// checked against queue-based FIFO and flag predictions.
module tb_qspi_oversampled;
    localparam int          HALF = 6;
    localparam int          D4   = 8;
    localparam int          D1   = 4;
    localparam logic [7:0]  FILL = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n, sclk, ncs4, ncs1;
    logic       io4_oe, io1_oe, io1_d;
    logic [3:0] io4_d;
    wire  [3:0] io4, io1;
    logic [7:0] rd_data4, rd_data1, wr_data4, wr_data1;
    logic       rd_valid4, rd_ready4, wr_valid4, wr_ready4, closed4, rx_overflow4, tx_underrun4;
    logic       rd_valid1, rd_ready1, wr_valid1, wr_ready1, closed1, rx_overflow1, tx_underrun1;

    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [7:0]  rx4_q[$], tx4_q[$], rx1_q[$];
    bit          send4, ovf4, und4;

    always #5 clk = ~clk;

    assign io4    = io4_oe ? io4_d : 4'bzzzz;
    assign io1[0] = io1_oe ? io1_d : 1'bz;
    for (genvar g = 0; g < 4; g++) begin : g_pull
        pulldown (io4[g]);
        pulldown (io1[g]);
    end

    qspi_oversampled #(.LANES(4), .DEPTH(D4), .SYNC_STAGES(2), .FILL_BYTE(FILL)) u4 (
        .clk(clk), .async_reset_n(rst_n), .qspi_clk(sclk), .qspi_ncs(ncs4), .qspi_io(io4),
        .rd_data(rd_data4), .rd_valid(rd_valid4), .rd_ready(rd_ready4), .wr_data(wr_data4),
        .wr_valid(wr_valid4), .wr_ready(wr_ready4), .closed(closed4),
        .rx_overflow(rx_overflow4), .tx_underrun(tx_underrun4));

    qspi_oversampled #(.LANES(1), .DEPTH(D1), .SYNC_STAGES(2), .FILL_BYTE(FILL)) u1 (
        .clk(clk), .async_reset_n(rst_n), .qspi_clk(sclk), .qspi_ncs(ncs1), .qspi_io(io1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ready(rd_ready1), .wr_data(wr_data1),
        .wr_valid(wr_valid1), .wr_ready(wr_ready1), .closed(closed1),
        .rx_overflow(rx_overflow1), .tx_underrun(tx_underrun1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One host byte (or nbeats nibbles) on the 4-lane link; MISO sampled at each SCLK rise.
    task automatic byte4(input logic [7:0] mosi, input bit drive, input int nbeats,
                         output logic [7:0] miso);
        miso = '0;
        for (int b = 0; b < nbeats; b++) begin
            if (drive) begin
                io4_oe = 1'b1;
                io4_d  = mosi[7-4*b -: 4];
            end
            clks(HALF);
            sclk = 1'b1;
            miso[7-4*b -: 4] = io4;
            clks(1);
            if (b == 1) io4_oe = 1'b0;
            clks(HALF - 1);
            sclk = 1'b0;
        end
    endtask

    task automatic host_byte4(input logic [7:0] mosi);
        logic [7:0] miso, expv;
        if (send4) begin
            byte4(mosi, 1'b0, 2, miso);
            if (tx4_q.size() > 0) expv = tx4_q.pop_front();
            else begin
                expv = FILL;
                und4 = 1'b1;
            end
            chk("miso4", {24'd0, miso}, {24'd0, expv});
        end else begin
            byte4(mosi, 1'b1, 2, miso);
            if (rx4_q.size() < D4) rx4_q.push_back(mosi);
            else ovf4 = 1'b1;
            if (tx4_q.size() > 0) send4 = 1'b1;
            else chk("lanes_z4", {28'd0, io4}, 32'd0);
        end
        chk("rx_overflow4", {31'd0, rx_overflow4}, {31'd0, ovf4});
        chk("tx_underrun4", {31'd0, tx_underrun4}, {31'd0, und4});
    endtask

    task automatic host_byte1(input logic [7:0] mosi);
        for (int b = 0; b < 8; b++) begin
            io1_oe = 1'b1;
            io1_d  = mosi[7-b];
            clks(HALF);
            sclk = 1'b1;
            clks(1);
            if (b == 7) io1_oe = 1'b0;
            clks(HALF - 1);
            sclk = 1'b0;
        end
        if (rx1_q.size() < D1) rx1_q.push_back(mosi);
        chk("miso_z1", {31'd0, io1[1]}, 32'd0);
    endtask

    task automatic begin4();
        ncs4  = 1'b0;
        send4 = 1'b0;
        ovf4  = 1'b0;
        und4  = 1'b0;
        clks(HALF);
    endtask

    task automatic end4();
        clks(HALF);
        io4_oe = 1'b0;
        ncs4   = 1'b1;
        clks(HALF);
        chk("closed4", {31'd0, closed4}, 32'd1);
    endtask

    task automatic push4(input logic [7:0] b);
        chk("wr_valid4", {31'd0, wr_valid4}, {31'd0, (tx4_q.size() < D4)});
        wr_data4  = b;
        wr_ready4 = 1'b1;
        clks(1);
        wr_ready4 = 1'b0;
        if (tx4_q.size() < D4) tx4_q.push_back(b);
        if (rx4_q.size() > 0) void'(rx4_q.pop_front());
    endtask

    task automatic pop4();
        while (rx4_q.size() > 0) begin
            chk("rd_valid4", {31'd0, rd_valid4}, 32'd1);
            chk("rd_data4", {24'd0, rd_data4}, {24'd0, rx4_q.pop_front()});
            rd_ready4 = 1'b1;
            clks(1);
            rd_ready4 = 1'b0;
        end
        chk("rx_empty4", {31'd0, rd_valid4}, 32'd0);
    endtask

    task automatic pop1();
        while (rx1_q.size() > 0) begin
            chk("rd_valid1", {31'd0, rd_valid1}, 32'd1);
            chk("rd_data1", {24'd0, rd_data1}, {24'd0, rx1_q.pop_front()});
            rd_ready1 = 1'b1;
            clks(1);
            rd_ready1 = 1'b0;
        end
        chk("rx_empty1", {31'd0, rd_valid1}, 32'd0);
    endtask

    initial begin
        logic [7:0] m, b6;
        rst_n = 1'b0; sclk = 1'b0; ncs4 = 1'b1; ncs1 = 1'b1;
        io4_oe = 1'b0; io4_d = '0; io1_oe = 1'b0; io1_d = 1'b0;
        rd_ready4 = 1'b0; wr_ready4 = 1'b0; wr_data4 = '0;
        rd_ready1 = 1'b0; wr_ready1 = 1'b0; wr_data1 = '0;
        clks(3);
        chk("rst_rd_valid", {31'd0, rd_valid4}, 32'd0);
        chk("rst_wr_valid", {31'd0, wr_valid4}, 32'd1);
        chk("rst_closed", {31'd0, closed4}, 32'd1);
        chk("rst_overflow", {31'd0, rx_overflow4}, 32'd0);
        chk("rst_underrun", {31'd0, tx_underrun4}, 32'd0);
        chk("rst_lanes_z", {28'd0, io4}, 32'd0);
        rst_n = 1'b1;
        clks(4);

        // Quad receive: directed nibbles then random bytes.
        begin4();
        host_byte4(8'h4A);
        host_byte4(8'h5B);
        for (int i = 0; i < 3; i++) host_byte4(8'($urandom));
        end4();
        pop4();

        // Single-lane receive.
        ncs1 = 1'b0;
        clks(HALF);
        host_byte1(8'hA5);
        host_byte1(8'($urandom));
        clks(HALF);
        ncs1 = 1'b1;
        clks(HALF);
        chk("closed1", {31'd0, closed1}, 32'd1);
        pop1();

        // Send after command byte, then underrun fill.
        push4(8'h3C);
        push4(8'($urandom));
        begin4();
        host_byte4(8'($urandom));
        for (int i = 0; i < 3; i++) host_byte4(8'h00);
        end4();
        chk("underrun_sticky", {31'd0, tx_underrun4}, 32'd1);
        pop4();

        // Fill TX to full, overfill is ignored, drain through the pointer wrap.
        for (int i = 0; i < D4; i++) push4(8'($urandom));
        chk("tx_full", {31'd0, wr_valid4}, 32'd0);
        push4(8'($urandom));
        begin4();
        host_byte4(8'($urandom));
        for (int i = 0; i < D4 + 1; i++) host_byte4(8'h00);
        end4();
        pop4();

        // RX overflow and flag clearing on the next select.
        begin4();
        chk("underrun_cleared", {31'd0, tx_underrun4}, 32'd0);
        for (int i = 0; i < D4 + 1; i++) host_byte4(8'($urandom));
        end4();
        chk("overflow_sticky", {31'd0, rx_overflow4}, 32'd1);
        pop4();
        begin4();
        chk("overflow_cleared", {31'd0, rx_overflow4}, 32'd0);
        end4();

        // Partial byte is discarded; next transaction realigns.
        begin4();
        byte4(8'($urandom), 1'b1, 1, m);
        end4();
        chk("partial_no_push", {31'd0, rd_valid4}, 32'd0);
        begin4();
        host_byte4(8'($urandom));
        host_byte4(8'($urandom));
        end4();
        pop4();

        // Reset in the middle of a send.
        b6 = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
        push4(b6);
        push4(8'($urandom));
        begin4();
        host_byte4(8'($urandom));
        byte4(8'h00, 1'b0, 1, m);
        chk("t6_hi_nibble", {28'd0, m[7:4]}, {28'd0, b6[7:4]});
        clks(HALF);
        chk("t6_lo_nibble", {28'd0, io4}, {28'd0, b6[3:0]});
        rst_n = 1'b0;
        #1;
        chk("t6_lanes_z", {28'd0, io4}, 32'd0);
        clks(1);
        ncs4 = 1'b1;
        rx4_q.delete();
        tx4_q.delete();
        clks(3);
        rst_n = 1'b1;
        clks(4);
        chk("t6_rd_valid", {31'd0, rd_valid4}, 32'd0);
        chk("t6_wr_valid", {31'd0, wr_valid4}, 32'd1);
        chk("t6_closed", {31'd0, closed4}, 32'd1);
        begin4();
        host_byte4(8'($urandom));
        host_byte4(8'($urandom));
        end4();
        pop4();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
